// File: rtl/toplevel_soc_pio_edge_in_if.sv
// Avalon-MM slave bus for the edge-capturing input PIO.
// The host drives the address/strobe/data side; the PIO returns read data and its IRQ.
interface toplevel_soc_pio_edge_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/toplevel_soc_pio_edge_in.sv
// Parallel input port with an edge-capture register.
// It synchronises in_port and shows the live level at DATA.
// Selected edges set sticky bits in EDGE_CAP, which software clears by writing ones (W1C).
// A level IRQ is raised from the masked captures.
// After reset, a short warm-up suppresses detection until the synchroniser and the
// delay flop hold real samples, so a line held high through reset is not seen as an edge.
module toplevel_soc_pio_edge_in #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in_port,
  toplevel_soc_pio_edge_in_if.slave  bus
);

  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int CW       = $clog2(WARM_MAX + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [CW-1:0]    warm_cnt;
  logic             warm_done;
  logic             wr;
  logic             wr_mask;
  logic             wr_cap;
  logic [31:0]      rd_next;
  logic [31:0]      readdata_q;
  logic             unused_wdata;

  // Synchroniser chain plus the one-flop delay used for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Warm-up counter: counts up after reset release and saturates at WARM_MAX
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + CW'(1);
  end

  assign warm_done = (warm_cnt == CW'(WARM_MAX));

  // Per-bit edge select, gated off until the pipeline holds real samples
  always_comb begin
    rise   = sync & ~prev;
    fall   = ~sync & prev;
    detect = '0;
    if (warm_done) begin
      if (EDGE_TYPE == 0)      detect = rise;
      else if (EDGE_TYPE == 1) detect = fall;
      else                     detect = rise | fall;
    end
  end

  assign wr      = bus.chipselect & ~bus.write_n;
  assign wr_mask = wr && (bus.address == 2'd2);
  assign wr_cap  = wr && (bus.address == 2'd3);
  assign clr     = wr_cap ? bus.writedata[WIDTH-1:0] : '0;

  // Writedata bits above WIDTH are intentionally ignored
  assign unused_wdata = ^bus.writedata;

  // Mask register and sticky capture; a new edge beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_mask) irq_mask <= bus.writedata[WIDTH-1:0];
      edge_cap <= detect | (edge_cap & ~clr);
    end
  end

  // Read mux, zero-extended to the 32-bit bus
  always_comb begin
    rd_next = '0;
    case (bus.address)
      2'd0:    rd_next[WIDTH-1:0] = sync;
      2'd2:    rd_next[WIDTH-1:0] = irq_mask;
      2'd3:    rd_next[WIDTH-1:0] = edge_cap;
      default: rd_next = '0;
    endcase
  end

  // Read data is registered every cycle whether or not the slave is selected
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= rd_next;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_toplevel_soc_pio_edge_in.sv
// Bench for the edge-capturing input PIO.
// Two instances share the same stimulus: one detects rising edges, the other any edge.
// A model checks both every cycle, using a history of input samples and the register
// rules. Literal checks at the key moments pin the model itself.
module tb_toplevel_soc_pio_edge_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_port;
  logic [1:0]  address;
  logic        cs;
  logic        wn;
  logic [31:0] wdata;

  int errors = 0;
  int checks = 0;

  toplevel_soc_pio_edge_in_if bus0 ();
  toplevel_soc_pio_edge_in_if bus2 ();

  assign bus0.address = address;  assign bus2.address = address;
  assign bus0.chipselect = cs;    assign bus2.chipselect = cs;
  assign bus0.write_n = wn;       assign bus2.write_n = wn;
  assign bus0.writedata = wdata;  assign bus2.writedata = wdata;

  toplevel_soc_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_rise (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus0)
  );

  toplevel_soc_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_any (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model. Captures are driven by the input as seen SYNC_STAGES clocks late, and
  // edges count only once at least SYNC_STAGES+1 samples exist since reset release.
  logic [7:0]  samples[$];
  int          since_rel;
  logic [7:0]  m_cap [2];
  logic [7:0]  m_mask [2];
  logic [31:0] m_rd [2];

  function automatic logic [7:0] level_at(input int d);
    if (samples.size() > d) return samples[samples.size()-1-d];
    return 8'h00;
  endfunction

  // Model update at each clock edge; reset clears it at once
  always @(posedge clk or negedge reset_n) begin : model
    logic [7:0] s, p, up, dn, det;
    if (!reset_n) begin
      samples.delete();
      since_rel = 0;
      for (int k = 0; k < 2; k++) begin
        m_cap[k] = 8'h00; m_mask[k] = 8'h00; m_rd[k] = 32'h0;
      end
    end else begin
      s  = level_at(1);
      p  = level_at(2);
      up = s & ~p;
      dn = ~s & p;
      for (int k = 0; k < 2; k++) begin
        det = 8'h00;
        if (since_rel >= 3) det = (k == 0) ? up : (up | dn);
        case (address)
          2'd0:    m_rd[k] = {24'h0, s};
          2'd2:    m_rd[k] = {24'h0, m_mask[k]};
          2'd3:    m_rd[k] = {24'h0, m_cap[k]};
          default: m_rd[k] = 32'h0;
        endcase
        if (cs && !wn && address == 2'd3) m_cap[k] = det | (m_cap[k] & ~wdata[7:0]);
        else                              m_cap[k] = det | m_cap[k];
        if (cs && !wn && address == 2'd2) m_mask[k] = wdata[7:0];
      end
      samples.push_back(in_port);
      if (samples.size() > 4) void'(samples.pop_front());
      if (since_rel < 100) since_rel++;
    end
  end

  // Compare both instances against the model every cycle
  always @(negedge clk) begin
    check("rd_rise",  bus0.readdata, m_rd[0]);
    check("irq_rise", {31'h0, bus0.irq}, {31'h0, |(m_cap[0] & m_mask[0])});
    check("rd_any",   bus2.readdata, m_rd[1]);
    check("irq_any",  {31'h0, bus2.irq}, {31'h0, |(m_cap[1] & m_mask[1])});
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; cs = 1'b1; wn = 1'b0; wdata = d;
    @(negedge clk);
    cs = 1'b0; wn = 1'b1; wdata = 32'h0; address = 2'd3;
  endtask

  initial begin
    in_port = 8'hA5; address = 2'd0; cs = 1'b0; wn = 1'b1; wdata = 32'h0;
    wait_n(3);
    check("reset_rd",  bus0.readdata, 32'h0);
    check("reset_irq", {31'h0, bus0.irq}, 32'h0);
    reset_n = 1'b1;
    wait_n(2);
    check("data_early", bus0.readdata, 32'h0);
    wait_n(1);
    check("data_3clk", bus0.readdata, 32'h0000_00A5);
    address = 2'd3;
    wait_n(1);
    check("cap_after_reset_rise", bus0.readdata, 32'h0);
    check("cap_after_reset_any",  bus2.readdata, 32'h0);

    // Rising edge on bit0 with bit0 unmasked
    in_port = 8'hA4; wait_n(4);
    wr(2'd3, 32'hFF); wr(2'd2, 32'h01);
    in_port = 8'hA5;
    wait_n(2);
    check("irq_before_cap", {31'h0, bus0.irq}, 32'h0);
    wait_n(1);
    check("irq_on_cap", {31'h0, bus0.irq}, 32'h1);
    wait_n(1);
    check("cap_rise", bus0.readdata, 32'h01);
    in_port = 8'hA4; wait_n(4);
    check("cap_after_fall", bus0.readdata, 32'h01);

    // W1C and no-op clear
    wr(2'd3, 32'h01);
    check("irq_after_clear", {31'h0, bus0.irq}, 32'h0);
    in_port = 8'hA5; wait_n(4);
    wr(2'd3, 32'h00);
    check("irq_after_zero_w1c", {31'h0, bus0.irq}, 32'h1);
    wait_n(1);
    check("cap_after_zero_w1c", bus0.readdata, 32'h01);

    // Clear lands on the same edge as a new capture
    in_port = 8'hA4; wait_n(4);
    in_port = 8'hA5; wait_n(2);
    address = 2'd3; cs = 1'b1; wn = 1'b0; wdata = 32'h01;
    @(negedge clk);
    cs = 1'b0; wn = 1'b1; wdata = 32'h0;
    check("collision_irq", {31'h0, bus0.irq}, 32'h1);
    wait_n(1);
    check("collision_cap", bus0.readdata, 32'h01);

    // Mask gating
    wr(2'd3, 32'hFF);
    in_port = 8'h25; wait_n(4);
    wr(2'd3, 32'hFF);
    in_port = 8'hA5; wait_n(4);
    check("mask_blocks_irq", {31'h0, bus0.irq}, 32'h0);
    check("mask_cap_bit7", bus0.readdata, 32'h80);
    wr(2'd2, 32'h80);
    check("mask_enables_irq", {31'h0, bus0.irq}, 32'h1);

    // Any-edge instance: both directions of bit3 capture
    wr(2'd3, 32'hFF);
    in_port = 8'hAD; wait_n(4);
    check("any_rise_bit3", bus2.readdata, 32'h08);
    wr(2'd3, 32'hFF);
    in_port = 8'hA5; wait_n(4);
    check("any_fall_bit3", bus2.readdata, 32'h08);

    // Writes to DATA and RSVD are ignored
    wr(2'd0, 32'hFFFF_FFFF); wr(2'd1, 32'hFFFF_FFFF);
    address = 2'd1; wait_n(2);
    check("rsvd_reads_zero", bus0.readdata, 32'h0);
    address = 2'd0; wait_n(2);
    check("data_read_only", bus0.readdata, 32'h0000_00A5);
    address = 2'd2; wait_n(2);
    check("mask_kept", bus0.readdata, 32'h80);

    // Reset mid-operation with an input high through reset
    address = 2'd3;
    in_port = 8'hAD; wait_n(4);
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("midreset_rd",  bus0.readdata, 32'h0);
    check("midreset_irq", {31'h0, bus0.irq}, 32'h0);
    reset_n = 1'b1;
    wait_n(8);
    check("no_cap_after_rereset", bus0.readdata, 32'h0);
    check("no_cap_after_rereset_any", bus2.readdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
